// File: rtl/scope_pkg.sv
// Shared scope constants: capture FSM state encoding and display colours
// used by the grid and waveform renderers.
package scope_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_WAIT = 3'd1;
  localparam state_t ST_CAP  = 3'd2;
  localparam state_t ST_DONE = 3'd3;

  // 12-bit RGB444 palette
  localparam logic [11:0] COLOR_BG   = 12'h000;
  localparam logic [11:0] COLOR_GRID = 12'h333;
  localparam logic [11:0] COLOR_AXIS = 12'h666;
  localparam logic [11:0] COLOR_WAVE = 12'h0F0;
  localparam logic [11:0] COLOR_TRIG = 12'hF80;

endpackage

// File: rtl/scope_trig_detect.sv
// Edge trigger detector with auto-mode timeout. Compares each valid sample
// against the previous one; state is cleared whenever arm is low.
module scope_trig_detect #(
  parameter int SAMPLE_W = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                arm,
  input  logic                auto_en,
  input  logic                trig_slope,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                trig,
  output logic                forced
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);

  logic [SAMPLE_W-1:0] prev;
  logic                prev_valid;
  logic [TO_W-1:0]     to_cnt;
  logic                rise, fall, edge_hit, to_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      to_cnt     <= '0;
    end else if (!arm) begin
      prev_valid <= 1'b0;
      to_cnt     <= '0;
    end else if (sample_valid) begin
      prev       <= sample;
      prev_valid <= 1'b1;
      // saturate so a late auto_en still forces on the next sample
      if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
    end
  end

  always_comb begin
    rise     = (prev < trig_level) && (sample >= trig_level);
    fall     = (prev > trig_level) && (sample <= trig_level);
    edge_hit = prev_valid && (trig_slope ? rise : fall);
    to_hit   = auto_en && (to_cnt == TO_MAX);
    trig     = arm && sample_valid && (edge_hit || to_hit);
    forced   = arm && sample_valid && to_hit && !edge_hit;
  end

endmodule

// File: rtl/scope_capture_ctrl.sv
// Waveform acquisition sequencer: trigger, DEPTH-sample capture into the back
// bank of a ping-pong RAM, bank swap only at frame_start.
module scope_capture_ctrl
  import scope_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int DEPTH    = 400,
  parameter int ADDR_W   = 9,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                frame_start,
  input  logic                run,
  input  logic                single,
  input  logic                auto_en,
  input  logic                trig_slope,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                wr_en,
  output logic                wr_bank,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic                disp_bank,
  output logic                disp_forced,
  output logic [2:0]          state,
  output logic [7:0]          frame_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              nxt;
  logic                arm, trig, trig_forced;
  logic                write, last_wr, swap, pend_any;
  logic [ADDR_W-1:0]   cap_addr;
  logic                cap_forced, single_pend;

  scope_trig_detect #(
    .SAMPLE_W (SAMPLE_W),
    .TIMEOUT  (TIMEOUT)
  ) u_trig (
    .clk          (clk),
    .reset_n      (reset_n),
    .arm          (arm),
    .auto_en      (auto_en),
    .trig_slope   (trig_slope),
    .trig_level   (trig_level),
    .sample_valid (sample_valid),
    .sample       (sample),
    .trig         (trig),
    .forced       (trig_forced)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (run || single) nxt = ST_WAIT;
      ST_WAIT: if (trig)          nxt = ST_CAP;
      ST_CAP:  if (last_wr)       nxt = ST_DONE;
      ST_DONE: if (swap)          nxt = (run || pend_any) ? ST_WAIT : ST_IDLE;
      default:                    nxt = ST_IDLE;
    endcase
  end

  // A frame_start landing while the final write is still on the bus is
  // skipped, so the renderer never flips onto a bank mid-write.
  always_comb begin
    arm      = (state == ST_WAIT);
    write    = trig || ((state == ST_CAP) && sample_valid);
    last_wr  = (state == ST_CAP) && sample_valid && (cap_addr == LAST_ADDR);
    swap     = (state == ST_DONE) && frame_start && !wr_en;
    pend_any = single_pend || single;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cap_addr   <= '0;
      cap_forced <= 1'b0;
    end else begin
      wr_en <= write;
      if (write) begin
        wr_addr  <= cap_addr;
        wr_data  <= sample;
        cap_addr <= cap_addr + 1'b1;
      end else if (state != ST_CAP) begin
        cap_addr <= '0;
      end
      if (trig) cap_forced <= trig_forced;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank     <= 1'b1;
      disp_bank   <= 1'b0;
      disp_forced <= 1'b0;
      frame_cnt   <= '0;
      single_pend <= 1'b0;
    end else if (swap) begin
      disp_bank   <= wr_bank;
      wr_bank     <= ~wr_bank;
      disp_forced <= cap_forced;
      frame_cnt   <= frame_cnt + 1'b1;
      single_pend <= 1'b0;
    end else if (single && (state != ST_IDLE)) begin
      single_pend <= 1'b1;
    end
  end

endmodule
